// File: rtl/buf_pkg.sv
// Shared constants and FSM state types for the bf16 accelerator host buffer interface.
// The optional tlast checker in buf_stream_ctl is enabled with BUF_STREAM_TLAST_CHECK_EN.
package buf_pkg;

   // Buffer word-address width: 2 banks x 512 words, bit AW-1 selects the bank
   localparam int AW = 10;

   // Stream and buffer word width
   localparam int DW = 64;

   // Words per bank
   localparam int BANK_WORDS = 512;

   // Source (load) path states
   typedef enum logic [0:0] {
      SRC_IDLE = 1'b0,
      SRC_LOAD = 1'b1
   } srcState_e;

   // Destination (drain) path states
   typedef enum logic [1:0] {
      DST_IDLE  = 2'd0,
      DST_READ  = 2'd1,
      DST_FLUSH = 2'd2
   } dstState_e;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry first-word-fall-through FIFO with valid/ready handshakes on both sides.
// The head entry is presented on out_data_o as soon as it is written.
module stream_fifo2 #(
   parameter int W = buf_pkg::DW + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] in_data_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   output logic [W-1:0] out_data_o,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [1:0]   count_o
);
   import buf_pkg::*;

   logic [W-1:0] mem_q [2];
   logic         wrPtr_q, wrPtr_d;
   logic         rdPtr_q, rdPtr_d;
   logic [1:0]   count_q, count_d;
   logic         push;
   logic         pop;

   assign in_ready_o  = (count_q != 2'd2);
   assign out_valid_o = (count_q != 2'd0);
   assign out_data_o  = mem_q[rdPtr_q];
   assign count_o     = count_q;
   assign push        = in_valid_i & in_ready_o;
   assign pop         = out_valid_o & out_ready_i;

   // Advance the pointers and occupancy for this cycle's push and pop
   always_comb begin
      wrPtr_d = wrPtr_q ^ push;
      rdPtr_d = rdPtr_q ^ pop;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
   end

   // Storage and pointer registers; reset empties the FIFO and clears stale data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            mem_q[i] <= '0;
         end
         wrPtr_q <= 1'b0;
         rdPtr_q <= 1'b0;
         count_q <= 2'd0;
      end else begin
         if (push) begin
            mem_q[wrPtr_q] <= in_data_i;
         end
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/buf_stream_ctl.sv
// Host-side end of the bf16 accelerator buffer interface.
// Load path: AXI-Stream slave -> source-buffer write strobes.
// Drain path: destination-buffer reads -> 2-entry FIFO -> AXI-Stream master.
// Optional macro BUF_STREAM_TLAST_CHECK_EN enables the sticky s_tlast consistency flag on err.
module buf_stream_ctl #(
   parameter int AW = buf_pkg::AW,
   parameter int DW = buf_pkg::DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          src_start,
   input  logic [AW:0]   src_len,
   input  logic          dst_start,
   input  logic [AW:0]   dst_len,
   input  logic [DW-1:0] s_tdata,
   input  logic          s_tvalid,
   input  logic          s_tlast,
   output logic          s_tready,
   output logic [DW-1:0] m_tdata,
   output logic          m_tvalid,
   output logic          m_tlast,
   input  logic          m_tready,
   output logic          src_v,
   output logic [AW-1:0] src_a,
   output logic [DW-1:0] src_d,
   output logic          dst_v,
   output logic [AW-1:0] dst_a,
   input  logic [DW-1:0] dst_d,
   output logic          src_busy,
   output logic          dst_busy,
   output logic          src_done,
   output logic          dst_done,
   output logic          err
);
   import buf_pkg::*;

   localparam logic [AW:0] LEN_ONE = {{AW{1'b0}}, 1'b1};

   // ---------------------------------------------------------------
   // Load path
   // ---------------------------------------------------------------
   srcState_e   srcState_q, srcState_d;
   logic [AW:0] srcLen_q, srcLen_d;
   logic [AW:0] srcCnt_q, srcCnt_d;
   logic        srcDone_q, srcDone_d;
   logic        srcBeat;
   logic        srcLast;

   assign s_tready = (srcState_q == SRC_LOAD);
   assign srcBeat  = s_tvalid & s_tready;
   assign srcLast  = (srcCnt_q == (srcLen_q - LEN_ONE));
   assign src_v    = srcBeat;
   assign src_a    = srcCnt_q[AW-1:0];
   assign src_d    = srcBeat ? s_tdata : '0;
   assign src_busy = (srcState_q == SRC_LOAD);
   assign src_done = srcDone_q;

   // Load FSM: latch the count on start, stop counting at len-1 so the address never overruns
   always_comb begin
      srcState_d = srcState_q;
      srcLen_d   = srcLen_q;
      srcCnt_d   = srcCnt_q;
      srcDone_d  = 1'b0;
      case (srcState_q)
         SRC_IDLE: begin
            if (src_start) begin
               srcLen_d = src_len;
               srcCnt_d = '0;
               if (src_len == '0) begin
                  srcDone_d = 1'b1;
               end else begin
                  srcState_d = SRC_LOAD;
               end
            end
         end
         SRC_LOAD: begin
            if (srcBeat) begin
               if (srcLast) begin
                  srcState_d = SRC_IDLE;
                  srcDone_d  = 1'b1;
               end else begin
                  srcCnt_d = srcCnt_q + LEN_ONE;
               end
            end
         end
         default: srcState_d = SRC_IDLE;
      endcase
   end

   // Load path state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         srcState_q <= SRC_IDLE;
         srcLen_q   <= '0;
         srcCnt_q   <= '0;
         srcDone_q  <= 1'b0;
      end else begin
         srcState_q <= srcState_d;
         srcLen_q   <= srcLen_d;
         srcCnt_q   <= srcCnt_d;
         srcDone_q  <= srcDone_d;
      end
   end

`ifdef BUF_STREAM_TLAST_CHECK_EN
   logic err_q, err_d;

   // Sticky flag: tlast must be high exactly on the final beat; cleared by the next accepted start
   always_comb begin
      err_d = err_q;
      if ((srcState_q == SRC_IDLE) && src_start) begin
         err_d = 1'b0;
      end else if (srcBeat && (s_tlast != srcLast)) begin
         err_d = 1'b1;
      end
   end

   // Error flag register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   logic unusedTlast;

   assign unusedTlast = s_tlast;
   assign err         = 1'b0;
`endif

   // ---------------------------------------------------------------
   // Drain path
   // ---------------------------------------------------------------
   dstState_e     dstState_q, dstState_d;
   logic [AW:0]   dstLen_q, dstLen_d;
   logic [AW:0]   dstCnt_q, dstCnt_d;
   logic [AW-1:0] dstLastAddr_q, dstLastAddr_d;
   logic          inflight_q, inflight_d;
   logic          inflightLast_q, inflightLast_d;
   logic          dstDone_q, dstDone_d;
   logic [AW-1:0] rdAddr;
   logic [2:0]    dstOcc;
   logic          roomOk;
   logic          bankStall;
   logic          dstIssue;
   logic          dstLastIssue;
   logic [1:0]    fifoCount;
   logic          fifoOutValid;
   logic          fifoOutLast;
   logic [DW-1:0] fifoOutData;
   logic          fifoPop;
   logic          unusedFifoInReady;

   assign rdAddr       = dstCnt_q[AW-1:0];
   assign fifoPop      = fifoOutValid & m_tready;
   assign dstOcc       = {1'b0, fifoCount} + {2'b00, inflight_q};
   assign roomOk       = dstOcc < (3'd2 + {2'b00, fifoPop});
   assign bankStall    = inflight_q && (rdAddr[AW-1] != dstLastAddr_q[AW-1]);
   assign dstIssue     = (dstState_q == DST_READ) && roomOk && !bankStall;
   assign dstLastIssue = (dstCnt_q == (dstLen_q - LEN_ONE));

   assign dst_v    = dstIssue;
   assign dst_a    = dstIssue ? rdAddr : dstLastAddr_q;
   assign m_tvalid = fifoOutValid;
   assign m_tdata  = fifoOutData;
   assign m_tlast  = fifoOutValid & fifoOutLast;
   assign dst_busy = (dstState_q != DST_IDLE);
   assign dst_done = dstDone_q;

   // Drain FSM: issue reads while fewer than two words are owed to the stream, hold off one
   // cycle when the next read would switch banks while the previous read's data is being captured
   always_comb begin
      dstState_d     = dstState_q;
      dstLen_d       = dstLen_q;
      dstCnt_d       = dstCnt_q;
      dstLastAddr_d  = dstLastAddr_q;
      inflight_d     = dstIssue;
      inflightLast_d = dstIssue & dstLastIssue;
      dstDone_d      = 1'b0;
      if (dstIssue) begin
         dstLastAddr_d = rdAddr;
      end
      case (dstState_q)
         DST_IDLE: begin
            if (dst_start) begin
               dstLen_d = dst_len;
               dstCnt_d = '0;
               if (dst_len == '0) begin
                  dstDone_d = 1'b1;
               end else begin
                  dstState_d = DST_READ;
               end
            end
         end
         DST_READ: begin
            if (dstIssue) begin
               if (dstLastIssue) begin
                  dstState_d = DST_FLUSH;
               end else begin
                  dstCnt_d = dstCnt_q + LEN_ONE;
               end
            end
         end
         DST_FLUSH: begin
            if (fifoPop && fifoOutLast) begin
               dstState_d = DST_IDLE;
               dstDone_d  = 1'b1;
            end
         end
         default: dstState_d = DST_IDLE;
      endcase
   end

   // Drain path state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dstState_q     <= DST_IDLE;
         dstLen_q       <= '0;
         dstCnt_q       <= '0;
         dstLastAddr_q  <= '0;
         inflight_q     <= 1'b0;
         inflightLast_q <= 1'b0;
         dstDone_q      <= 1'b0;
      end else begin
         dstState_q     <= dstState_d;
         dstLen_q       <= dstLen_d;
         dstCnt_q       <= dstCnt_d;
         dstLastAddr_q  <= dstLastAddr_d;
         inflight_q     <= inflight_d;
         inflightLast_q <= inflightLast_d;
         dstDone_q      <= dstDone_d;
      end
   end

   // Read data arrives one cycle after issue and is captured with its last-word marker
   stream_fifo2 #(
      .W (DW + 1)
   ) uOutFifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_data_i   ({inflightLast_q, dst_d}),
      .in_valid_i  (inflight_q),
      .in_ready_o  (unusedFifoInReady),
      .out_data_o  ({fifoOutLast, fifoOutData}),
      .out_valid_o (fifoOutValid),
      .out_ready_i (m_tready),
      .count_o     (fifoCount)
   );

endmodule

// File: tb/tb_buf_stream_ctl.sv
// Self-checking bench for buf_stream_ctl.
// Load beats and drain words are queued as expectations when driven and compared as the
// DUT produces them. The destination buffer is modelled as two banks with registered reads
// muxed by the current dst_a bank bit, so a missing bank bubble corrupts the drained data.
module tb_buf_stream_ctl;

   localparam int AW = 10;
   localparam int DW = 64;

   logic          clk;
   logic          rst_n;
   logic          src_start;
   logic [AW:0]   src_len;
   logic          dst_start;
   logic [AW:0]   dst_len;
   logic [DW-1:0] s_tdata;
   logic          s_tvalid;
   logic          s_tlast;
   logic          s_tready;
   logic [DW-1:0] m_tdata;
   logic          m_tvalid;
   logic          m_tlast;
   logic          m_tready;
   logic          src_v;
   logic [AW-1:0] src_a;
   logic [DW-1:0] src_d;
   logic          dst_v;
   logic [AW-1:0] dst_a;
   logic [DW-1:0] dst_d;
   logic          src_busy;
   logic          dst_busy;
   logic          src_done;
   logic          dst_done;
   logic          err;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int readyPct = 100;
   int loadId = 0;
   int dstLenCur = 0;
   int issued = 0;
   int taken = 0;
   int maxOut = 0;
   int cyc511 = 0;
   int lastTakenCyc = 0;
   bit bubbleSeen = 0;
   logic [AW-1:0] srcExpAddr = '0;
   logic [AW-1:0] dstExpAddr = '0;
   logic [AW-1:0] dstLastIssued = '0;
   logic [DW-1:0] bank0Q = '0;
   logic [DW-1:0] bank1Q = '0;

   logic [AW-1:0] srcAddrQ [$];
   logic [DW-1:0] srcDataQ [$];
   logic [DW:0]   dstQ [$];

   buf_stream_ctl #(
      .AW (AW),
      .DW (DW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .src_start (src_start),
      .src_len   (src_len),
      .dst_start (dst_start),
      .dst_len   (dst_len),
      .s_tdata   (s_tdata),
      .s_tvalid  (s_tvalid),
      .s_tlast   (s_tlast),
      .s_tready  (s_tready),
      .m_tdata   (m_tdata),
      .m_tvalid  (m_tvalid),
      .m_tlast   (m_tlast),
      .m_tready  (m_tready),
      .src_v     (src_v),
      .src_a     (src_a),
      .src_d     (src_d),
      .dst_v     (dst_v),
      .dst_a     (dst_a),
      .dst_d     (dst_d),
      .src_busy  (src_busy),
      .dst_busy  (dst_busy),
      .src_done  (src_done),
      .dst_done  (dst_done),
      .err       (err)
   );

   // Content of destination-buffer word at a full address
   function automatic logic [DW-1:0] dstWord(input logic [AW-1:0] a);
      return {16'hD5D5, 6'd0, a, 22'd0, ~a};
   endfunction

   // Content of source beat i for a given load
   function automatic logic [DW-1:0] srcWord(input int id, input int i);
      return (64'(id) << 48) | 64'(32'h11 * (i + 1));
   endfunction

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter used for latency and bubble measurements
   always @(posedge clk) begin
      cyc <= cyc + 1;
   end

   // Two-bank destination buffer: each bank registers its read, output muxed by dst_a bank bit
   always @(posedge clk) begin
      if (dst_v) begin
         bank0Q <= dstWord({1'b0, dst_a[AW-2:0]});
         bank1Q <= dstWord({1'b1, dst_a[AW-2:0]});
      end
   end
   assign dst_d = dst_a[AW-1] ? bank1Q : bank0Q;

   // Output-stream consumer: ready drawn each cycle with probability readyPct
   initial begin
      m_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_tready = ($urandom_range(0, 99) < readyPct);
      end
   end

   // Count one comparison and report it if the observed value differs
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed=%0h expected=%0h at cycle %0d", tag, observed, expected, cyc);
      end
   endtask

   // Every output must read zero while reset is held
   task automatic checkAllZero(input string prefix);
      checkOutput({prefix, "Flags"},
                  {54'd0, s_tready, src_v, dst_v, m_tvalid, m_tlast, src_busy, dst_busy, src_done, dst_done, err},
                  64'd0);
      checkOutput({prefix, "SrcA"}, 64'(src_a), 64'd0);
      checkOutput({prefix, "SrcD"}, src_d, 64'd0);
      checkOutput({prefix, "DstA"}, 64'(dst_a), 64'd0);
      checkOutput({prefix, "MData"}, m_tdata, 64'd0);
   endtask

   // Monitor: compare load strobes and stream output against the scoreboard queues
   always @(negedge clk) begin
      if (dst_start) begin
         dstExpAddr = '0;
      end
      if (src_v) begin
         if (srcDataQ.size() == 0) begin
            checkOutput("srcUnexpected", 64'd1, 64'd0);
         end else begin
            checkOutput("srcA", 64'(src_a), 64'(srcAddrQ.pop_front()));
            checkOutput("srcD", src_d, srcDataQ.pop_front());
         end
      end
      if (dst_v) begin
         checkOutput("dstA", 64'(dst_a), 64'(dstExpAddr));
         if (dst_a == 10'd511) begin
            cyc511 = cyc;
         end
         if (dst_a == 10'd512) begin
            checkOutput("bankBubble", 64'(cyc - cyc511), 64'd2);
            bubbleSeen = 1'b1;
         end
         dstLastIssued = dst_a;
         dstExpAddr++;
         issued++;
      end else if (dst_busy) begin
         checkOutput("dstAHold", 64'(dst_a), 64'(dstLastIssued));
      end
      if (m_tvalid && m_tready) begin
         taken++;
         if (dstQ.size() == 0) begin
            checkOutput("dstUnexpected", 64'd1, 64'd0);
         end else begin
            logic [DW:0] exp;
            exp = dstQ.pop_front();
            checkOutput("mData", m_tdata, exp[DW-1:0]);
            checkOutput("mLast", 64'(m_tlast), 64'(exp[DW]));
            if (exp[DW]) begin
               lastTakenCyc = cyc;
            end
         end
      end
      if ((issued - taken) > maxOut) begin
         maxOut = issued - taken;
      end
      if (dst_done && (dstLenCur > 0)) begin
         checkOutput("dstDoneLag", 64'(cyc - lastTakenCyc), 64'd1);
      end
   end

   // Pulse src_start with a word count
   task automatic startLoad(input logic [AW:0] len);
      src_start  = 1'b1;
      src_len    = len;
      srcExpAddr = '0;
      @(posedge clk);
      #1;
      src_start = 1'b0;
   endtask

   // Offer one beat and queue the write it must produce
   task automatic driveBeat(input logic [DW-1:0] data, input logic last);
      srcAddrQ.push_back(srcExpAddr);
      srcDataQ.push_back(data);
      srcExpAddr++;
      s_tvalid = 1'b1;
      s_tdata  = data;
      s_tlast  = last;
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   // Full load of len back-to-back beats; optional tlast position and a start pulse while busy
   task automatic applyStimulus(input int len, input int tlastBeat, input int busyStartBeat);
      startLoad(11'(len));
      if (len > 0) begin
         checkOutput("srcBusy", 64'(src_busy), 64'd1);
      end
      for (int i = 0; i < len; i++) begin
         if (i == busyStartBeat) begin
            src_start = 1'b1;
            src_len   = 11'd10;
         end
         driveBeat(srcWord(loadId, i), (i == tlastBeat));
         src_start = 1'b0;
      end
      loadId++;
      @(negedge clk);
      checkOutput("srcDone", 64'(src_done), 64'd1);
      checkOutput("srcBusyDrop", 64'(src_busy), 64'd0);
      @(posedge clk);
      #1;
      checkOutput("srcDonePulse", 64'(src_done), 64'd0);
      if (tlastBeat == len - 1) begin
         checkOutput("errClean", 64'(err), 64'd0);
      end
   endtask

   // Drain len words with the given output-ready probability, wait (bounded) for dst_done
   task automatic applyDrain(input int len, input int pct);
      int c;
      bit seen;
      readyPct  = pct;
      dstLenCur = len;
      for (int i = 0; i < len; i++) begin
         dstQ.push_back({(i == len - 1), dstWord(10'(i))});
      end
      dst_start = 1'b1;
      dst_len   = 11'(len);
      @(posedge clk);
      #1;
      dst_start = 1'b0;
      if (len > 0) begin
         checkOutput("dstBusy", 64'(dst_busy), 64'd1);
      end
      seen = 1'b0;
      for (c = 0; c < len * 20 + 20; c++) begin
         @(negedge clk);
         if (dst_done) begin
            seen = 1'b1;
            break;
         end
      end
      checkOutput("dstDoneSeen", 64'(seen), 64'd1);
      if (len == 0) begin
         checkOutput("dstZeroDoneLat", 64'(c), 64'd0);
      end
      checkOutput("dstQEmpty", 64'(dstQ.size()), 64'd0);
      checkOutput("dstBusyDrop", 64'(dst_busy), 64'd0);
      readyPct = 100;
      @(posedge clk);
      #1;
   endtask

   // Main sequence
   initial begin
      rst_n     = 1'b0;
      src_start = 1'b0;
      src_len   = '0;
      dst_start = 1'b0;
      dst_len   = '0;
      s_tdata   = '0;
      s_tvalid  = 1'b0;
      s_tlast   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkAllZero("rst");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Load of 4 beats 0x11..0x44, then an empty load
      applyStimulus(4, 3, -1);
      applyStimulus(0, -1, -1);

      // Start pulse during a load must be ignored
      applyStimulus(3, 2, 1);

      // Drain of 3 words at full rate, then an empty drain
      applyDrain(3, 100);
      applyDrain(0, 100);

      // Backpressured drain concurrently with an independent load
      fork
         applyDrain(64, 30);
         applyStimulus(8, 7, -1);
      join

      // Drain across the bank boundary
      applyDrain(1024, 100);
      checkOutput("bubbleSeen", 64'(bubbleSeen), 64'd1);

      // Misplaced tlast on beat 2
      applyStimulus(4, 1, -1);
`ifdef BUF_STREAM_TLAST_CHECK_EN
      checkOutput("errSet", 64'(err), 64'd1);
      applyStimulus(0, -1, -1);
      checkOutput("errCleared", 64'(err), 64'd0);
`else
      checkOutput("errTiedLow", 64'(err), 64'd0);
`endif

      // Reset in the middle of a 10-beat load, with beat 6 being offered
      startLoad(11'd10);
      for (int i = 0; i < 5; i++) begin
         driveBeat(srcWord(loadId, i), 1'b0);
      end
      s_tvalid = 1'b1;
      s_tdata  = srcWord(loadId, 5);
      #2;
      rst_n = 1'b0;
      #1;
      checkAllZero("midRst");
      s_tvalid = 1'b0;
      loadId++;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(4, 3, -1);

      checkOutput("srcQEmpty", 64'(srcDataQ.size()), 64'd0);
      checkOutput("maxOutstandingOk", 64'(maxOut <= 2), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Safety net against a hung handshake
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed=timeout expected=completion");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
